// File: rtl/z_event_counter.sv
// -----------------------------------------------------------------------------
// z_event_counter
//
// Counts rising edges of the run detector's registered z output as a two-digit
// BCD value and drives two active-low 7-segment displays for the lab board.
//
// Ports
//   Clock   in   1  system clock, all state updates on posedge
//   Reset   in   1  asynchronous, active-low reset
//   z       in   1  detector output, synchronous to Clock
//   En      in   1  count enable (edges seen while low are dropped)
//   Clr     in   1  synchronous clear of count and overflow
//   Pulse   out  1  one-cycle strobe per detected z rising edge
//   Tens    out  4  BCD tens digit
//   Ones    out  4  BCD ones digit
//   Ovf     out  1  sticky overflow flag
//   HEX1    out  7  active-low segments {g,f,e,d,c,b,a} for Tens
//   HEX0    out  7  active-low segments for Ones
//   EState  out  2  current edge-FSM state (debug)
//
// Parameter
//   WRAP    1 = count wraps 99 -> 00, 0 = count saturates at 99
//
// Handshake: Pulse is a pure strobe with no back-pressure. It is high for
// exactly one cycle per event, and Tens/Ones/Ovf already show the updated
// count in that same cycle.
// -----------------------------------------------------------------------------
module z_event_counter #(
  parameter bit WRAP = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       z,
  input  logic       En,
  input  logic       Clr,
  output logic       Pulse,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Ovf,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic [1:0] EState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIT  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       w_edge;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       r_ovf;

  // ---------------------------------------------------------------------------
  // Edge FSM. It follows z unconditionally, so raising En while z is already
  // high cannot manufacture an event.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = IDLE;
    case (r_state)
      IDLE:    w_next_state = z ? HIT : IDLE;
      HIT:     w_next_state = z ? HOLD : IDLE;
      HOLD:    w_next_state = z ? HOLD : IDLE;
      default: w_next_state = IDLE;  // encoding 2'd3 recovers to IDLE
    endcase
  end

  // The count changes on the same edge that moves the FSM IDLE -> HIT, so the
  // new value is visible in the cycle Pulse is high.
  assign w_edge = (r_state == IDLE) && z;

  // ---------------------------------------------------------------------------
  // BCD counter. Clr wins over a coincident edge; the edge is discarded but
  // the FSM still produces its Pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
      r_ovf  <= 1'b0;
    end else if (Clr) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
      r_ovf  <= 1'b0;
    end else if (w_edge && En) begin
      if (r_ones < 4'd9) begin
        r_ones <= r_ones + 4'd1;
      end else if (r_tens < 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 4'd1;
      end else begin
        // At 99: flag overflow, then either roll over or hold at 99.
        r_ovf <= 1'b1;
        if (WRAP) begin
          r_tens <= 4'd0;
          r_ones <= 4'd0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Active-low 7-segment decode, {g,f,e,d,c,b,a}. Codes 10-15 cannot occur in
  // a BCD digit; they blank the display as a safe fallback.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign Pulse  = (r_state == HIT);
  assign Tens   = r_tens;
  assign Ones   = r_ones;
  assign Ovf    = r_ovf;
  assign HEX1   = seg_decode(r_tens);
  assign HEX0   = seg_decode(r_ones);
  assign EState = r_state;

endmodule

// File: tb/tb_z_event_counter.sv
// -----------------------------------------------------------------------------
// tb_z_event_counter
//
// Drives one wrapping and one saturating instance from the same stimulus.
// A reference model keeps each count as a plain integer 0..99 and tracks how
// long z has been high; BCD digits and segment patterns are derived from that.
// -----------------------------------------------------------------------------
module tb_z_event_counter;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset_n;
  logic z_in;
  logic en_in;
  logic clr_in;

  always #10 clock = ~clock;

  logic       pulse_w, ovf_w, pulse_s, ovf_s;
  logic [3:0] tens_w, ones_w, tens_s, ones_s;
  logic [6:0] hex1_w, hex0_w, hex1_s, hex0_s;
  logic [1:0] estate_w, estate_s;

  z_event_counter #(.WRAP(1'b1)) u_wrap (
    .Clock(clock), .Reset(reset_n), .z(z_in), .En(en_in), .Clr(clr_in),
    .Pulse(pulse_w), .Tens(tens_w), .Ones(ones_w), .Ovf(ovf_w),
    .HEX1(hex1_w), .HEX0(hex0_w), .EState(estate_w)
  );

  z_event_counter #(.WRAP(1'b0)) u_sat (
    .Clock(clock), .Reset(reset_n), .z(z_in), .En(en_in), .Clr(clr_in),
    .Pulse(pulse_s), .Tens(tens_s), .Ones(ones_s), .Ovf(ovf_s),
    .HEX1(hex1_s), .HEX0(hex0_s), .EState(estate_s)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int   m_cnt_w;
  int   m_cnt_s;
  bit   m_ovf_w;
  bit   m_ovf_s;
  int   m_run;     // consecutive high samples of z since reset, capped at 2
  bit   mon_en;
  logic [6:0] seg_tbl [10];

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q [$];

  initial begin
    seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001;
    seg_tbl[2] = 7'b0100100; seg_tbl[3] = 7'b0110000;
    seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
    seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000;
    seg_tbl[8] = 7'b0000000; seg_tbl[9] = 7'b0010000;
  end

  task automatic model_reset();
    m_cnt_w = 0;
    m_cnt_s = 0;
    m_ovf_w = 1'b0;
    m_ovf_s = 1'b0;
    m_run   = 0;
  endtask

  function automatic logic [17:0] model_pack();
    logic [3:0] tw, ow, ts, os;
    tw = 4'(m_cnt_w / 10);
    ow = 4'(m_cnt_w % 10);
    ts = 4'(m_cnt_s / 10);
    os = 4'(m_cnt_s % 10);
    return {m_ovf_w, tw, ow, m_ovf_s, ts, os};
  endfunction

  function automatic int exp_state();
    return (m_run == 0) ? 0 : ((m_run == 1) ? 1 : 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply inputs, let one posedge happen, advance the model.
  // ---------------------------------------------------------------------------
  task automatic step(input logic zi, input logic ei, input logic ci);
    bit ev;
    z_in   = zi;
    en_in  = ei;
    clr_in = ci;
    @(posedge clock);
    ev = zi && (m_run == 0);
    if (ci) begin
      m_cnt_w = 0; m_ovf_w = 1'b0;
      m_cnt_s = 0; m_ovf_s = 1'b0;
    end else if (ev && ei) begin
      if (m_cnt_w == 99) begin m_cnt_w = 0; m_ovf_w = 1'b1; end
      else m_cnt_w = m_cnt_w + 1;
      if (m_cnt_s == 99) m_ovf_s = 1'b1;
      else m_cnt_s = m_cnt_s + 1;
    end
    m_run = zi ? ((m_run < 2) ? m_run + 1 : 2) : 0;
    if (ev) exp_q.push_back(model_pack());
    @(negedge clock);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_pulse"},  {pulse_w, pulse_s}, 2'b00);
    chk({tag, "_estate"}, {estate_w, estate_s}, 4'd0);
    chk({tag, "_count"},  {tens_w, ones_w, tens_s, ones_s}, 16'h0000);
    chk({tag, "_ovf"},    {ovf_w, ovf_s}, 2'b00);
    chk({tag, "_hex"},    {hex1_w, hex0_w, hex1_s, hex0_s},
        {4{7'b1000000}});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    if (mon_en) begin
      logic [17:0] e;
      e = model_pack();
      chk("pulse_w", pulse_w, (m_run == 1));
      chk("pulse_s", pulse_s, (m_run == 1));
      chk("estate_w", estate_w, exp_state());
      chk("estate_s", estate_s, exp_state());
      chk("count", {ovf_w, tens_w, ones_w, ovf_s, tens_s, ones_s}, e);
      chk("hex_w", {hex1_w, hex0_w}, {seg_tbl[m_cnt_w / 10], seg_tbl[m_cnt_w % 10]});
      chk("hex_s", {hex1_s, hex0_s}, {seg_tbl[m_cnt_s / 10], seg_tbl[m_cnt_s % 10]});
      if (pulse_w || pulse_s) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {pulse_w, pulse_s}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk("event", {ovf_w, tens_w, ones_w, ovf_s, tens_s, ones_s}, e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    mon_en  = 1'b0;
    reset_n = 1'b0;
    z_in    = 1'b0;
    en_in   = 1'b1;
    clr_in  = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check_zero_outputs("reset");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Idle after reset.
    repeat (5) step(1'b0, 1'b1, 1'b0);

    // One long high run gives one event.
    repeat (6) step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    chk("one_event_hex0", hex0_w, 7'b1111001);

    // Single-cycle toggles: three events.
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    chk("toggle_count", {tens_w, ones_w}, 8'h04);

    // Fill to 99, then the 100th event overflows.
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 99; i++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    chk("at_99", {tens_w, ones_w, tens_s, ones_s}, 16'h9999);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("overflow", {ovf_w, tens_w, ones_w, ovf_s, tens_s, ones_s},
        {1'b1, 8'h00, 1'b1, 8'h99});
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1);
    chk("clear", {ovf_w, tens_w, ones_w, ovf_s, tens_s, ones_s}, 18'd0);

    // Clr coincident with an edge; En low during an edge.
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
    // Raising En while z is already high is not an event.
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    chk("en_gating", {tens_w, ones_w}, 8'h01);

    // Count to 05 with z left high, then asynchronous reset mid-cycle.
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("pre_reset", {tens_w, ones_w}, 8'h05);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("async_reset");
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("post_reset", {estate_w, tens_w, ones_w}, {2'd1, 8'h01});
    step(1'b0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 31) == 0));
    end
    repeat (2) step(1'b0, 1'b1, 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
